mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - loader, cpu and memory bus bundle for mem_arbiter
interface mem_arbiter_if;
  logic [31:0] l_addr;
  logic [7:0]  l_wdata;
  logic        l_rd;
  logic        l_wr;
  logic [7:0]  l_rdata;
  logic        l_ack;
  logic [31:0] c_addr;
  logic [7:0]  c_wdata;
  logic        c_rd;
  logic        c_wr;
  logic [7:0]  c_rdata;
  logic        c_ack;
  logic [31:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;
  logic        m_read_en;
  logic        m_write_en;
  logic        m_ready;

  modport slave (
    input  l_addr, l_wdata, l_rd, l_wr, c_addr, c_wdata, c_rd, c_wr, m_rdata, m_ready,
    output l_rdata, l_ack, c_rdata, c_ack, m_addr, m_wdata, m_read_en, m_write_en
  );

  modport master (
    output l_addr, l_wdata, l_rd, l_wr, c_addr, c_wdata, c_rd, c_wr, m_rdata, m_ready,
    input  l_rdata, l_ack, c_rdata, c_ack, m_addr, m_wdata, m_read_en, m_write_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester byte memory arbiter with access timeout
// Optional MEM_ARBITER_ROUND_ROBIN_EN: alternate grants on contention instead of loader priority.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_if.slave    bus,
  output logic [1:0]      owner,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       last_cpu;
  logic       l_req;
  logic       c_req;
  logic       pick_cpu;

  always_comb begin
    l_req = bus.l_rd | bus.l_wr;
    c_req = bus.c_rd | bus.c_wr;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    pick_cpu = c_req && (!l_req || !last_cpu);
`else
    pick_cpu = c_req && !l_req;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      last_cpu       <= 1'b1;
      owner          <= 2'b00;
      timeout        <= 1'b0;
      bus.l_rdata    <= 8'h00;
      bus.l_ack      <= 1'b0;
      bus.c_rdata    <= 8'h00;
      bus.c_ack      <= 1'b0;
      bus.m_addr     <= 32'd0;
      bus.m_wdata    <= 8'h00;
      bus.m_read_en  <= 1'b0;
      bus.m_write_en <= 1'b0;
    end else begin
      bus.l_ack <= 1'b0;
      bus.c_ack <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (l_req || c_req) begin
            state    <= ACCESS;
            cnt      <= 8'd0;
            last_cpu <= pick_cpu;
            if (pick_cpu) begin
              owner          <= 2'b10;
              bus.m_addr     <= bus.c_addr;
              bus.m_wdata    <= bus.c_wdata;
              bus.m_write_en <= bus.c_wr;
              bus.m_read_en  <= !bus.c_wr;
            end else begin
              owner          <= 2'b01;
              bus.m_addr     <= bus.l_addr;
              bus.m_wdata    <= bus.l_wdata;
              bus.m_write_en <= bus.l_wr;
              bus.m_read_en  <= !bus.l_wr;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 8'd1;
          // Completion and timeout share the exit path; only the returned byte differs.
          if (bus.m_ready || cnt == LAST_CNT) begin
            state          <= DONE;
            bus.m_read_en  <= 1'b0;
            bus.m_write_en <= 1'b0;
            timeout        <= !bus.m_ready;
            if (owner[0]) begin
              bus.l_ack <= 1'b1;
              if (bus.m_read_en) bus.l_rdata <= bus.m_ready ? bus.m_rdata : 8'h00;
            end else begin
              bus.c_ack <= 1'b1;
              if (bus.m_read_en) bus.c_rdata <= bus.m_ready ? bus.m_rdata : 8'h00;
            end
          end
        end
        DONE: begin
          owner <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

  typedef struct packed {
    logic        lrd;
    logic        lwr;
    logic [31:0] la;
    logic [7:0]  lwd;
    logic        crd;
    logic        cwr;
    logic [31:0] ca;
    logic [7:0]  cwd;
    logic [7:0]  mrd;
    logic [7:0]  dly;
    logic [1:0]  e_own;
    logic        e_we;
    logic [7:0]  e_en;
    logic [31:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_to;
    logic [7:0]  e_lrd;
    logic [7:0]  e_crd;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] owner;
  logic       timeout;
  int         checks;
  int         failures;
  int         en_cnt;
  int         cur_dly;
  logic [7:0] cur_mrd;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .owner(owner),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory model: ready is raised in enable cycle number cur_dly+1.
  task automatic step_mem();
    if (bus.m_read_en || bus.m_write_en) begin
      en_cnt++;
      bus.m_ready = (en_cnt - 1 >= cur_dly);
      bus.m_rdata = cur_mrd;
    end else begin
      bus.m_ready = 1'b0;
    end
  endtask

  task automatic drop_reqs();
    bus.l_rd = 0; bus.l_wr = 0; bus.c_rd = 0; bus.c_wr = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [1:0]  got_own;
    logic        got_we;
    logic [31:0] got_addr;
    logic [7:0]  got_wd;
    logic [1:0]  got_ack;
    logic        got_to;
    logic [7:0]  got_lrd;
    logic [7:0]  got_crd;
    bit          acked;
    got_own = 0; got_we = 0; got_addr = 0; got_wd = 0; got_ack = 0; got_to = 0;
    got_lrd = 0; got_crd = 0; acked = 0;
    bus.l_rd = v.lrd; bus.l_wr = v.lwr; bus.l_addr = v.la; bus.l_wdata = v.lwd;
    bus.c_rd = v.crd; bus.c_wr = v.cwr; bus.c_addr = v.ca; bus.c_wdata = v.cwd;
    cur_dly = int'(v.dly); cur_mrd = v.mrd; en_cnt = 0;
    for (int i = 0; i < 30 && !acked; i++) begin
      @(negedge clk);
      if (got_own == 2'b00) got_own = owner;
      if (bus.m_read_en || bus.m_write_en) begin
        got_we = bus.m_write_en; got_addr = bus.m_addr; got_wd = bus.m_wdata;
      end
      step_mem();
      if (bus.l_ack || bus.c_ack) begin
        acked = 1; got_ack = {bus.c_ack, bus.l_ack}; got_to = timeout;
        got_lrd = bus.l_rdata; got_crd = bus.c_rdata;
        drop_reqs();
      end
    end
    chk($sformatf("v%0d_ack_seen", idx), 32'(acked), 32'd1);
    chk($sformatf("v%0d_owner", idx), 32'(got_own), 32'(v.e_own));
    chk($sformatf("v%0d_ack_who", idx), 32'(got_ack), 32'(v.e_own));
    chk($sformatf("v%0d_we", idx), 32'(got_we), 32'(v.e_we));
    chk($sformatf("v%0d_en_cycles", idx), 32'(en_cnt), 32'(v.e_en));
    chk($sformatf("v%0d_addr", idx), got_addr, v.e_addr);
    chk($sformatf("v%0d_wdata", idx), 32'(got_wd), 32'(v.e_wd));
    chk($sformatf("v%0d_timeout", idx), 32'(got_to), 32'(v.e_to));
    chk($sformatf("v%0d_l_rdata", idx), 32'(got_lrd), 32'(v.e_lrd));
    chk($sformatf("v%0d_c_rdata", idx), 32'(got_crd), 32'(v.e_crd));
    @(negedge clk);
    step_mem();
    chk($sformatf("v%0d_owner_after", idx), 32'(owner), 32'd0);
    chk($sformatf("v%0d_ack_clear", idx), 32'({bus.c_ack, bus.l_ack, timeout}), 32'd0);
  endtask

  vec_t vecs [7];
  logic [1:0] who [4];
  int         ack_cyc [4];
  logic [1:0] exp_who [4];

  initial begin
    int n;
    checks = 0; failures = 0; en_cnt = 0; cur_dly = 0; cur_mrd = 8'h00;
    rst_n = 1'b0;
    drop_reqs();
    bus.l_addr = 0; bus.l_wdata = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.m_rdata = 0; bus.m_ready = 0;

    //          lrd lwr la       lwd    crd cwr ca       cwd    mrd    dly     own  we en    addr     wd     to  lrd    crd
    vecs[0] = '{1'b0, 1'b1, 32'h10, 8'hA5, 1'b0, 1'b0, 32'h0,  8'h00, 8'h00, 8'd0,   2'b01, 1'b1, 8'd1, 32'h10, 8'hA5, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 32'h0,  8'h00, 1'b1, 1'b0, 32'h10, 8'h00, 8'hA5, 8'd0,   2'b10, 1'b0, 8'd1, 32'h10, 8'h00, 1'b0, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 8'h00, 1'b0, 1'b0, 32'h0,  8'h00, 8'h3C, 8'd2,   2'b01, 1'b0, 8'd3, 32'h20, 8'h00, 1'b0, 8'h3C, 8'hA5};
    vecs[3] = '{1'b0, 1'b0, 32'h0,  8'h00, 1'b1, 1'b1, 32'h44, 8'h5A, 8'hFF, 8'd1,   2'b10, 1'b1, 8'd2, 32'h44, 8'h5A, 1'b0, 8'h3C, 8'hA5};
    vecs[4] = '{1'b0, 1'b0, 32'h0,  8'h00, 1'b1, 1'b0, 32'h48, 8'h00, 8'h99, 8'd255, 2'b10, 1'b0, 8'd4, 32'h48, 8'h00, 1'b1, 8'h3C, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 32'h30, 8'h00, 1'b0, 1'b1, 32'h50, 8'h11, 8'h77, 8'd0,   2'b01, 1'b0, 8'd1, 32'h30, 8'h00, 1'b0, 8'h77, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 32'h34, 8'h22, 1'b0, 1'b0, 32'h0,  8'h00, 8'h00, 8'd255, 2'b01, 1'b1, 8'd4, 32'h34, 8'h22, 1'b1, 8'h77, 8'h00};

    repeat (2) @(negedge clk);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_enables", 32'({bus.m_read_en, bus.m_write_en}), 32'd0);
    chk("rst_acks", 32'({bus.l_ack, bus.c_ack, timeout}), 32'd0);
    chk("rst_rdata", 32'({bus.l_rdata, bus.c_rdata}), 32'd0);
    chk("rst_maddr", bus.m_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: both read, held across four accesses.
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    exp_who = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_who = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    bus.l_rd = 1; bus.l_addr = 32'h100; bus.c_rd = 1; bus.c_addr = 32'h200;
    cur_dly = 0; cur_mrd = 8'h00; n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(negedge clk);
      if (bus.m_read_en || bus.m_write_en) en_cnt = 0;
      step_mem();
      if (bus.l_ack || bus.c_ack) begin
        who[n] = {bus.c_ack, bus.l_ack};
        ack_cyc[n] = cyc;
        n++;
        if (n == 4) drop_reqs();
      end
    end
    chk("cont_acks", 32'(n), 32'd4);
    for (int i = 0; i < n; i++) chk($sformatf("cont_who%0d", i), 32'(who[i]), 32'(exp_who[i]));
    for (int i = 1; i < n; i++) chk($sformatf("cont_spacing%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Stray m_ready while idle must not produce any activity.
    bus.m_ready = 1; bus.m_rdata = 8'hEE;
    repeat (3) @(negedge clk);
    chk("idle_ready_owner", 32'(owner), 32'd0);
    chk("idle_ready_acks", 32'({bus.l_ack, bus.c_ack, timeout, bus.m_read_en, bus.m_write_en}), 32'd0);
    chk("idle_ready_rdata", 32'({bus.l_rdata, bus.c_rdata}), 32'h7700);
    bus.m_ready = 0;

    // Reset in the middle of an access, request kept pending.
    bus.l_rd = 1; bus.l_addr = 32'h55; cur_dly = 255; cur_mrd = 8'h42; en_cnt = 0;
    repeat (2) begin @(negedge clk); step_mem(); end
    chk("mid_owner_before", 32'(owner), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_enables", 32'({bus.m_read_en, bus.m_write_en}), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_ack", 32'({bus.l_ack, bus.c_ack, timeout}), 32'd0);
    chk("mid_rst_rdata", 32'(bus.l_rdata), 32'd0);
    @(negedge clk);
    chk("mid_rst_hold_owner", 32'(owner), 32'd0);
    chk("mid_rst_hold_ack", 32'(bus.l_ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_owner", 32'(owner), 32'd1);
    chk("post_rst_read_en", 32'(bus.m_read_en), 32'd1);
    chk("post_rst_addr", bus.m_addr, 32'h55);
    cur_dly = 0; en_cnt = 0;
    step_mem();
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      @(negedge clk);
      step_mem();
      if (bus.l_ack) begin
        n = 1;
        chk("post_rst_rdata", 32'(bus.l_rdata), 32'h42);
        drop_reqs();
      end
    end
    chk("post_rst_ack_seen", 32'(n), 32'd1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
